// File: rtl/jk_drv_pkg.sv
// Shared types and counter widths for the JK bank driver.
package jk_drv_pkg;

  localparam int unsigned SettleCntW = 4;
  localparam int unsigned RetryCntW  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck
  } state_e;

endpackage

// File: rtl/jk_bank_driver_if.sv
// Target handshake and flop-bank signals between control FSM, driver and JK bank.
interface jk_bank_driver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;

  // Requester/bank side
  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j, k, busy, done, err
  );

  // Driver side
  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j, k, busy, done, err
  );
endinterface

// File: rtl/jk_excite.sv
// JK excitation mapper: (current q, target t) -> (j, k), purely combinational.
// Define JK_TOGGLE_EN to drive changing bits with j=k=1 instead of set/reset.
module jk_excite #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  // Map each bit independently; unchanged bits always hold (j=k=0)
  always_comb begin
`ifdef JK_TOGGLE_EN
    j = q ^ t;
    k = q ^ t;
`else
    j = ~q & t;
    k = q & ~t;
`endif
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flops toward a requested target, reads Q back and
// retries up to MAX_RETRY times. Toggle encoding selectable via JK_TOGGLE_EN.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  jk_bank_driver_if.slave   bus
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      tgt_q, tgt_d;
  logic [WIDTH-1:0]      j_q, j_d, k_q, k_d;
  logic [SettleCntW-1:0] settle_q, settle_d;
  logic [RetryCntW-1:0]  retry_q, retry_d;
  logic                  done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0]      exc_t, exc_j, exc_k;

  // In IDLE the excitation is taken from the incoming request, later from the captured target
  assign exc_t = (state_q == StIdle) ? bus.tgt_data : tgt_q;

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .q (bus.q_fb),
    .t (exc_t),
    .j (exc_j),
    .k (exc_k)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    j_d      = '0;
    k_d      = '0;
    settle_d = settle_q;
    retry_d  = retry_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.tgt_valid) begin
          tgt_d   = bus.tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          retry_d = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleCntW'(SETTLE_CYC - 1)) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + SettleCntW'(1);
        end
      end
      StCheck: begin
        if (bus.q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (retry_q < RetryCntW'(MAX_RETRY)) begin
          retry_d = retry_q + RetryCntW'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = StDrive;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      settle_q <= '0;
      retry_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      settle_q <= settle_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.tgt_ready = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Testbench for jk_bank_driver: behavioural JK bank, request-level reference model.
module tb_jk_bank_driver;

  localparam int unsigned W          = 4;
  localparam int unsigned SETTLE_CYC = 1;
  localparam int unsigned MAX_RETRY  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jk_bank_driver_if #(.WIDTH(W)) bus ();

  jk_bank_driver #(
    .WIDTH      (W),
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural JK flop bank; stuck bits are forced to 0
  logic [W-1:0] bank_q;
  logic         load_en  = 1'b1;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] stuck    = '0;

  always @(posedge clk) begin
    if (load_en) bank_q <= load_val & ~stuck;
    else         bank_q <= ((bus.j & ~bank_q) | (~bus.k & bank_q)) & ~stuck;
  end
  assign bus.q_fb = bank_q;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_q = '0;

  task automatic preload(input logic [W-1:0] v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
    model_q  = v & ~stuck;
  endtask

  // Run one request through the model and compare every cycle until done
  task automatic run_req(input logic [W-1:0] t, input logic follow, input logic [W-1:0] follow_t);
    int           period;
    int           attempts;
    int           total;
    int           a;
    logic [W-1:0] q;
    logic [W-1:0] changed;
    logic [W-1:0] exp_j[$];
    logic [W-1:0] exp_k[$];
    logic [W-1:0] ej, ek;
    logic         exp_err;
    logic         fin;
    logic         got;
    logic [3:0]   st, exp_st;
    period   = 2 + SETTLE_CYC;
    attempts = 0;
    q        = model_q;
    fin      = 1'b0;
    exp_err  = 1'b0;
    while (!fin) begin
      changed = q ^ t;
`ifdef JK_TOGGLE_EN
      exp_j.push_back(changed);
      exp_k.push_back(changed);
`else
      exp_j.push_back(changed & t);
      exp_k.push_back(changed & q);
`endif
      q = t & ~stuck;
      attempts++;
      if (q == t) begin
        fin = 1'b1;
        exp_err = 1'b0;
      end else if (attempts > int'(MAX_RETRY)) begin
        fin = 1'b1;
        exp_err = 1'b1;
      end
    end
    total = attempts * period;

    bus.tgt_valid = 1'b1;
    bus.tgt_data  = t;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (bus.tgt_ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL handshake: tgt_ready never rose for target %b", t);
      bus.tgt_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (follow) begin
      bus.tgt_data = follow_t;
    end else begin
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = W'($urandom);
    end

    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      st = {bus.busy, bus.done, bus.err, bus.tgt_ready};
      if (c <= total) begin
        a  = (c - 1) / period;
        ej = ((c - 1) % period == 0) ? exp_j[a] : '0;
        ek = ((c - 1) % period == 0) ? exp_k[a] : '0;
        checks++;
        if ({bus.j, bus.k} !== {ej, ek}) begin
          errors++;
          $display("FAIL jk t=%b cyc=%0d: got j=%b k=%b, want j=%b k=%b",
                   t, c, bus.j, bus.k, ej, ek);
        end
        exp_st = 4'b1000;
      end else begin
        exp_st = {1'b0, 1'b1, exp_err, 1'b1};
        checks++;
        if (bus.q_fb !== q) begin
          errors++;
          $display("FAIL bank t=%b: got q=%b, want %b", t, bus.q_fb, q);
        end
      end
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL status t=%b cyc=%0d: got busy/done/err/ready=%b, want %b",
                 t, c, st, exp_st);
      end
    end
    model_q = q;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    load_en  = 1'b1;
    load_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    load_en = 1'b0;
    model_q = '0;
    @(negedge clk);
    checks++;
    if ({bus.j, bus.k, bus.busy, bus.done, bus.err, bus.tgt_ready} !== {{2*W{1'b0}}, 4'b0001}) begin
      errors++;
      $display("FAIL reset: got j=%b k=%b busy=%b done=%b err=%b ready=%b, want 0/0/0/0/0/1",
               bus.j, bus.k, bus.busy, bus.done, bus.err, bus.tgt_ready);
    end
  endtask

  task automatic test_set_bits();
    stuck = '0;
    preload(4'b0000);
    run_req(4'b1010, 1'b0, '0);
  endtask

  task automatic test_clear_bits();
    stuck = '0;
    preload(4'b1111);
    run_req(4'b0110, 1'b0, '0);
  endtask

  task automatic test_stuck_retry();
    stuck = 4'b0001;
    preload(4'b0000);
    run_req(4'b0001, 1'b0, '0);
    stuck = '0;
  endtask

  task automatic test_back_to_back();
    stuck = '0;
    preload(4'b0011);
    run_req(4'b1100, 1'b1, 4'b0101);
    run_req(4'b0101, 1'b0, '0);
  endtask

  task automatic test_reset_mid_request();
    logic got;
    stuck = '0;
    preload(4'b0000);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b0110;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      if (bus.tgt_ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.tgt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.j, bus.k, bus.busy, bus.done, bus.err, bus.tgt_ready} !== {{2*W{1'b0}}, 4'b0000}) begin
      errors++;
      $display("FAIL mid_reset: got j=%b k=%b busy=%b done=%b err=%b ready=%b, want all 0",
               bus.j, bus.k, bus.busy, bus.done, bus.err, bus.tgt_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.tgt_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset: got busy/done/err/ready=%b, want 0001",
               {bus.busy, bus.done, bus.err, bus.tgt_ready});
    end
    model_q = 4'b0110;
    run_req(4'b1001, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      stuck = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      preload(W'($urandom));
      run_req(W'($urandom), 1'b0, '0);
    end
    stuck = '0;
  endtask

  initial begin
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    test_reset();
    test_set_bits();
    test_clear_bits();
    test_stuck_retry();
    test_back_to_back();
    test_reset_mid_request();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
